voice_band_tracker: RTL and testbench

Multi-voice, sequential successor to the combinational note-to-band mapper. It accepts note events tagged with a voice index and a signed transpose, saturates the effective note, and computes band = min(note / NOTES_PER_BAND, NUM_BANDS-1) with an iterative subtractor, so no divider is inferred. It keeps a per-voice band table that the oscillator/wavetable banks read to pick the band-limited table for each voice.

---
 rtl/synth_band_pkg.sv | 44 ++++
 rtl/band_divider.sv | 79 +++++++
 rtl/voice_band_tracker.sv | 191 +++++++++++++++++++
 tb/tb_voice_band_tracker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_band_pkg.sv
// ---------------------------------------------------------------------------
// synth_band_pkg
// Shared definitions for the voice band tracker:
//   - default configuration and the note/band/voice widths derived from it
//   - FSM state encoding used by the tracker top level
//   - saturating add used to apply a signed transpose to a MIDI note
// No ports (package).
// ---------------------------------------------------------------------------
package synth_band_pkg;

    localparam int DEF_NUM_VOICES     = 8;
    localparam int DEF_NUM_BANDS      = 22;
    localparam int DEF_MIDI_NOTES     = 128;
    localparam int DEF_NOTES_PER_BAND = 6;
    localparam int DEF_TRANSPOSE_W    = 8;

    localparam int DEF_NOTE_W  = $clog2(DEF_MIDI_NOTES);
    localparam int DEF_BAND_W  = $clog2(DEF_NUM_BANDS);
    localparam int DEF_VOICE_W = $clog2(DEF_NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } band_state_e;

    // Adds a transpose to a note and clamps the result to [0, hi].
    // Operands arrive already sign/zero-extended by the caller, so the
    // sum cannot wrap.
    function automatic int signed sat_add(input int signed note,
                                          input int signed transpose,
                                          input int signed hi);
        int signed sum;
        sum = note + transpose;
        if (sum < 0) begin
            return 0;
        end
        if (sum > hi) begin
            return hi;
        end
        return sum;
    endfunction

endpackage

// File: rtl/band_divider.sv
// ---------------------------------------------------------------------------
// band_divider
// Iterative subtract-and-clamp unit: q = min(eff / NOTES_PER_BAND,
// NUM_BANDS-1), one subtraction per clock, so no divider is inferred.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous abort; drops any division in progress
//   start  in   load eff as the new dividend (rem = eff, q = 0)
//   eff    in   saturated effective note
//   done   out  high in the cycle the quotient is final (no further step)
//   q      out  current / final quotient
// ---------------------------------------------------------------------------
module band_divider
    import synth_band_pkg::*;
#(
    parameter int NUM_BANDS      = DEF_NUM_BANDS,
    parameter int NOTES_PER_BAND = DEF_NOTES_PER_BAND,
    parameter int NOTE_W         = DEF_NOTE_W,
    parameter int BAND_W         = DEF_BAND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              start,
    input  logic [NOTE_W-1:0] eff,
    output logic              done,
    output logic [BAND_W-1:0] q
);

    logic              busy_q, busy_d;
    logic [NOTE_W-1:0] rem_q, rem_d;
    logic [BAND_W-1:0] q_q, q_d;
    logic              step;

    // Another subtraction is due while a full band remains and the
    // quotient has not yet reached the top band.
    assign step = (32'(rem_q) >= NOTES_PER_BAND) && (32'(q_q) < NUM_BANDS - 1);

    // The cycle with no step left is the one that reports completion.
    assign done = busy_q && !step;
    assign q    = q_q;

    always_comb begin
        busy_d = busy_q;
        rem_d  = rem_q;
        q_d    = q_q;
        if (clr) begin
            busy_d = 1'b0;
            rem_d  = '0;
            q_d    = '0;
        end else if (start) begin
            busy_d = 1'b1;
            rem_d  = eff;
            q_d    = '0;
        end else if (busy_q) begin
            if (step) begin
                rem_d = rem_q - NOTE_W'(NOTES_PER_BAND);
                q_d   = q_q + 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
            q_q    <= '0;
        end else begin
            busy_q <= busy_d;
            rem_q  <= rem_d;
            q_q    <= q_d;
        end
    end

endmodule

// File: rtl/voice_band_tracker.sv
// ---------------------------------------------------------------------------
// voice_band_tracker
// Accepts note events per voice, applies a signed transpose with saturation,
// maps the effective note to a band through band_divider and keeps a
// per-voice band table that the oscillator banks read combinationally.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   clr            in   synchronous clear: table to 0, abort request
//   req_valid      in   note event valid
//   req_ready      out  high only in IDLE with clr low
//   req_voice      in   target voice
//   req_note       in   MIDI note
//   req_transpose  in   signed semitone offset
//   rsp_valid      out  one-cycle completion pulse
//   rsp_voice      out  voice of the completed request (held)
//   rsp_band       out  computed band (held)
//   rsp_changed    out  band differs from the previous table entry (held)
//   rd_voice       in   table read address
//   rd_band        out  table[rd_voice], combinational
// ---------------------------------------------------------------------------
module voice_band_tracker
    import synth_band_pkg::*;
#(
    parameter int NUM_VOICES     = DEF_NUM_VOICES,
    parameter int NUM_BANDS      = DEF_NUM_BANDS,
    parameter int MIDI_NOTES     = DEF_MIDI_NOTES,
    parameter int NOTES_PER_BAND = DEF_NOTES_PER_BAND,
    parameter int TRANSPOSE_W    = DEF_TRANSPOSE_W,
    localparam int NOTE_W  = $clog2(MIDI_NOTES),
    localparam int BAND_W  = $clog2(NUM_BANDS),
    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [VOICE_W-1:0]     req_voice,
    input  logic [NOTE_W-1:0]      req_note,
    input  logic [TRANSPOSE_W-1:0] req_transpose,
    output logic                   rsp_valid,
    output logic [VOICE_W-1:0]     rsp_voice,
    output logic [BAND_W-1:0]      rsp_band,
    output logic                   rsp_changed,
    input  logic [VOICE_W-1:0]     rd_voice,
    output logic [BAND_W-1:0]      rd_band
);

    // One bit wider than the wider of (note + sign bit) and transpose, so the
    // signed sum of the two never overflows before saturation.
    localparam int SUM_W = ((NOTE_W + 1 > TRANSPOSE_W) ? NOTE_W + 1 : TRANSPOSE_W) + 1;

    band_state_e        state_q, state_d;
    logic [VOICE_W-1:0] voice_q, voice_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [VOICE_W-1:0] rsp_voice_q, rsp_voice_d;
    logic [BAND_W-1:0]  rsp_band_q, rsp_band_d;
    logic               rsp_changed_q, rsp_changed_d;
    logic [BAND_W-1:0]  band_tab_q [NUM_VOICES];
    logic [BAND_W-1:0]  band_tab_d [NUM_VOICES];

    logic signed [TRANSPOSE_W-1:0] xpose_s;
    logic signed [SUM_W-1:0]       note_ext;
    logic signed [SUM_W-1:0]       xpose_ext;
    logic [NOTE_W-1:0]             eff;
    logic                          div_start;
    logic                          div_done;
    logic [BAND_W-1:0]             div_q;
    logic [BAND_W-1:0]             old_band;

    // Effective note: zero-extend the note, sign-extend the transpose, clamp.
    assign xpose_s   = req_transpose;
    assign note_ext  = SUM_W'(req_note);
    assign xpose_ext = SUM_W'(xpose_s);
    assign eff       = NOTE_W'(sat_add(int'(note_ext), int'(xpose_ext), MIDI_NOTES - 1));

    assign req_ready = (state_q == IDLE) && !clr;
    assign div_start = req_valid && req_ready;

    // The pulse is registered on entry to DONE; a clr landing in that same
    // cycle must still swallow it.
    assign rsp_valid   = rsp_valid_q && !clr;
    assign rsp_voice   = rsp_voice_q;
    assign rsp_band    = rsp_band_q;
    assign rsp_changed = rsp_changed_q;

    band_divider #(
        .NUM_BANDS      (NUM_BANDS),
        .NOTES_PER_BAND (NOTES_PER_BAND),
        .NOTE_W         (NOTE_W),
        .BAND_W         (BAND_W)
    ) u_band_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (div_start),
        .eff   (eff),
        .done  (div_done),
        .q     (div_q)
    );

    // Table reads by address match: an out-of-range voice (non power-of-two
    // NUM_VOICES) matches no entry and reads as 0.
    always_comb begin
        rd_band  = '0;
        old_band = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (VOICE_W'(i) == rd_voice) begin
                rd_band = band_tab_q[i];
            end
            if (VOICE_W'(i) == voice_q) begin
                old_band = band_tab_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        voice_d       = voice_q;
        rsp_valid_d   = 1'b0;
        rsp_voice_d   = rsp_voice_q;
        rsp_band_d    = rsp_band_q;
        rsp_changed_d = rsp_changed_q;
        band_tab_d    = band_tab_q;

        if (clr) begin
            state_d = IDLE;
            for (int i = 0; i < NUM_VOICES; i++) begin
                band_tab_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        voice_d = req_voice;
                        state_d = DIV;
                    end
                end
                DIV: begin
                    // Response fields are captured here so they are already
                    // stable during the DONE cycle.
                    if (div_done) begin
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_voice_d   = voice_q;
                        rsp_band_d    = div_q;
                        rsp_changed_d = (div_q != old_band);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (VOICE_W'(i) == voice_q) begin
                            band_tab_d[i] = rsp_band_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            voice_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_voice_q   <= '0;
            rsp_band_q    <= '0;
            rsp_changed_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                band_tab_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            voice_q       <= voice_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_voice_q   <= rsp_voice_d;
            rsp_band_q    <= rsp_band_d;
            rsp_changed_q <= rsp_changed_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                band_tab_q[i] <= band_tab_d[i];
            end
        end
    end

endmodule

// File: tb/tb_voice_band_tracker.sv
// ---------------------------------------------------------------------------
// tb_voice_band_tracker
// Self-checking bench for voice_band_tracker: directed vector table, corner
// sequences (held request, clr mid-division, clr in DONE, async reset) and
// randomized requests against a behavioural band model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_voice_band_tracker;

    localparam int NV  = 8;
    localparam int NB  = 22;
    localparam int NPB = 6;
    localparam int MN  = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_voice;
    logic [6:0] req_note;
    logic [7:0] req_transpose;
    logic       rsp_valid;
    logic [2:0] rsp_voice;
    logic [4:0] rsp_band;
    logic       rsp_changed;
    logic [2:0] rd_voice;
    logic [4:0] rd_band;

    int checks = 0;
    int errors = 0;
    int mtab [NV];

    typedef struct {
        int voice;
        int note;
        int tr;
        int band;
        int chg;
        int lat;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    voice_band_tracker #(
        .NUM_VOICES     (NV),
        .NUM_BANDS      (NB),
        .MIDI_NOTES     (MN),
        .NOTES_PER_BAND (NPB),
        .TRANSPOSE_W    (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_voice     (req_voice),
        .req_note      (req_note),
        .req_transpose (req_transpose),
        .rsp_valid     (rsp_valid),
        .rsp_voice     (rsp_voice),
        .rsp_band      (rsp_band),
        .rsp_changed   (rsp_changed),
        .rd_voice      (rd_voice),
        .rd_band       (rd_band)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Band of a note after transpose: clamp the sum to the MIDI range, then
    // integer-divide and clamp to the top band.
    function automatic int mdl_band(input int note, input int tr);
        int e;
        int b;
        e = note + tr;
        if (e < 0) e = 0;
        if (e > MN - 1) e = MN - 1;
        b = e / NPB;
        if (b > NB - 1) b = NB - 1;
        return b;
    endfunction

    // Reads every table entry (one per cycle) against the model table.
    task automatic chk_table(input string nm);
        for (int v = 0; v < NV; v++) begin
            step();
            rd_voice = 3'(v);
            #1;
            chk($sformatf("%s rd_band[%0d]", nm, v), 32'(rd_band), mtab[v]);
        end
    endtask

    // Issues one request at the current (IDLE) cycle and checks the response
    // and the old/new table read around DONE. Ends in the cycle after DONE.
    task automatic run_req(input int v, input int n, input int t,
                           input int exp_band, input int exp_chg, input int exp_lat,
                           input string nm);
        int cnt;
        req_voice     = 3'(v);
        req_note      = 7'(n);
        req_transpose = 8'(t);
        req_valid     = 1'b1;
        #1;
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
        chk({nm, " ready"}, 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        cnt = 1;
        while (rsp_valid !== 1'b1 && cnt < 60) begin
            step();
            cnt++;
        end
        chk({nm, " latency"}, cnt, exp_lat);
        chk({nm, " band"}, 32'(rsp_band), exp_band);
        chk({nm, " voice"}, 32'(rsp_voice), v);
        chk({nm, " changed"}, 32'(rsp_changed), exp_chg);
        rd_voice = 3'(v);
        #1;
        chk({nm, " rd old"}, 32'(rd_band), mtab[v]);
        mtab[v] = exp_band;
        step();
        chk({nm, " rd new"}, 32'(rd_band), mtab[v]);
        chk({nm, " pulse end"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        int cnt;
        int pulses;
        int v;
        int n;
        int t;
        int b;

        vecs[0]  = '{3,  60,    0, 10, 1, 12};
        vecs[1]  = '{0, 127,   20, 21, 1, 23};
        vecs[2]  = '{4,   5,  -12,  0, 0,  2};
        vecs[3]  = '{1,  35,    0,  5, 1,  7};
        vecs[4]  = '{1,  30,    0,  5, 0,  7};
        vecs[5]  = '{1,  36,    0,  6, 1,  8};
        vecs[6]  = '{5,   0,  127, 21, 1, 23};
        vecs[7]  = '{6, 127, -128,  0, 0,  2};
        vecs[8]  = '{3,  65,   -5, 10, 0, 12};
        vecs[9]  = '{7, 125,    0, 20, 1, 22};
        vecs[10] = '{7, 126,    0, 21, 1, 23};
        vecs[11] = '{2,   5,    0,  0, 0,  2};

        for (int i = 0; i < NV; i++) mtab[i] = 0;

        // Reset and read-back
        rst_n         = 1'b0;
        clr           = 1'b0;
        req_valid     = 1'b0;
        req_voice     = '0;
        req_note      = '0;
        req_transpose = '0;
        rd_voice      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset rsp_band", 32'(rsp_band), 0);
        chk("reset rsp_changed", 32'(rsp_changed), 0);
        chk_table("reset");
        step();

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].voice, vecs[i].note, vecs[i].tr,
                    vecs[i].band, vecs[i].chg, vecs[i].lat,
                    $sformatf("vec%0d", i));
        end
        chk_table("directed");
        step();

        // Held req_valid with changing data during DIV
        req_voice     = 3'd5;
        req_note      = 7'd50;
        req_transpose = 8'd0;
        req_valid     = 1'b1;
        #1;
        chk("held ready", 32'(req_ready), 1);
        step();
        cnt = 1;
        while (rsp_valid !== 1'b1 && cnt < 60) begin
            req_voice     = 3'($urandom_range(0, 7));
            req_note      = 7'($urandom_range(0, 127));
            req_transpose = 8'($urandom_range(0, 255));
            step();
            cnt++;
        end
        b = mdl_band(50, 0);
        chk("held first latency", cnt, b + 2);
        chk("held first band", 32'(rsp_band), b);
        chk("held first voice", 32'(rsp_voice), 5);
        chk("held first changed", 32'(rsp_changed), (b != mtab[5]) ? 1 : 0);
        mtab[5] = b;
        req_voice = 3'd6;
        req_note  = 7'd90;
        req_transpose = 8'd0;
        step();
        chk("held second ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        cnt = 1;
        while (rsp_valid !== 1'b1 && cnt < 60) begin
            step();
            cnt++;
        end
        b = mdl_band(90, 0);
        chk("held second latency", cnt, b + 2);
        chk("held second band", 32'(rsp_band), b);
        chk("held second voice", 32'(rsp_voice), 6);
        chk("held second changed", 32'(rsp_changed), (b != mtab[6]) ? 1 : 0);
        mtab[6] = b;
        step();

        // clr mid-DIV
        req_voice     = 3'd2;
        req_note      = 7'd100;
        req_transpose = 8'd0;
        req_valid     = 1'b1;
        #1;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        clr = 1'b1;
        #1;
        chk("clr div rsp_valid", 32'(rsp_valid), 0);
        chk("clr div req_ready low", 32'(req_ready), 0);
        step();
        clr = 1'b0;
        #1;
        chk("clr div req_ready after", 32'(req_ready), 1);
        for (int i = 0; i < NV; i++) mtab[i] = 0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("clr div no response", pulses, 0);
        chk_table("clr div");
        step();

        // clr landing in DONE
        req_voice     = 3'd1;
        req_note      = 7'd60;
        req_transpose = 8'd0;
        req_valid     = 1'b1;
        #1;
        step();
        req_valid = 1'b0;
        cnt = 1;
        while (rsp_valid !== 1'b1 && cnt < 60) begin
            step();
            cnt++;
        end
        chk("clr done latency", cnt, 12);
        clr = 1'b1;
        #1;
        chk("clr done rsp_valid", 32'(rsp_valid), 0);
        step();
        clr = 1'b0;
        #1;
        chk("clr done req_ready", 32'(req_ready), 1);
        chk_table("clr done");
        step();

        // Randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, NV - 1);
            n = $urandom_range(0, MN - 1);
            t = $urandom_range(0, 255);
            if (t > 127) t = t - 256;
            b = mdl_band(n, t);
            run_req(v, n, t, b, (b != mtab[v]) ? 1 : 0, b + 2,
                    $sformatf("rnd%0d v%0d n%0d t%0d", i, v, n, t));
        end
        chk_table("random");
        step();

        // Async reset while a request is in flight
        req_voice     = 3'd4;
        req_note      = 7'd127;
        req_transpose = 8'd0;
        req_valid     = 1'b1;
        #1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        rd_voice = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rsp_valid", 32'(rsp_valid), 0);
        chk("async rst rd_band", 32'(rd_band), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("async rst req_ready", 32'(req_ready), 1);
        for (int i = 0; i < NV; i++) mtab[i] = 0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("async rst no response", pulses, 0);
        chk_table("async rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
